// File: rtl/fft_sample_framer_pkg.sv
// fft_sample_framer_pkg
//   Shared definitions for the FFT sample framer: parameter defaults and the
//   framer FSM state encoding.
package fft_sample_framer_pkg;

  localparam int DATA_W_DEF     = 24;
  localparam int FFT_LEN_DEF    = 4096;
  localparam int FIFO_DEPTH_DEF = 16;

  // IDLE   : nothing presented, beat index parked at 0
  // STREAM : beats come from the FIFO/output register
  // PAD    : zero beats until the current frame's eop has been taken
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_PAD    = 2'd2
  } state_t;

endpackage

// File: rtl/fft_sample_framer_fifo.sv
// fft_sample_framer_fifo
//   Synchronous show-ahead FIFO (head visible on dout without a pop).
//   Ports:
//     MCLK, reset      clock, async active-low reset
//     flush            drop all contents (wins over push/pop)
//     push, din        write request / data; a push into a full FIFO is
//                      accepted only when a pop happens the same cycle
//     pop              consume head entry
//     dout             head entry (valid while !empty)
//     full, empty      occupancy flags
module fft_sample_framer_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 16
) (
  input  logic         MCLK,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge MCLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fft_sample_framer.sv
// fft_sample_framer
//   Buffers strobed real audio samples and streams them as Avalon-ST frames of
//   FFT_LEN beats (sop on beat 0, eop on beat FFT_LEN-1). A frame that cannot
//   be completed with real data (sample dropped, enable removed) is finished
//   with zero beats so the downstream core only ever sees whole frames.
//   Ports:
//     MCLK, reset             clock, async active-low reset
//     enable                  accept samples / stream frames
//     sample_strobe,sample_in one-cycle sample valid + data
//     sink_ready              downstream ready (ready latency 0)
//     sink_valid/sop/eop      beat valid and frame markers
//     sink_real, sink_imag    beat data (imag always 0)
//     overflow, overflow_clr  sticky drop flag and its clear pulse
module fft_sample_framer
  import fft_sample_framer_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FFT_LEN    = FFT_LEN_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              MCLK,
  input  logic              reset,
  input  logic              enable,
  input  logic              sample_strobe,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sink_ready,
  output logic              sink_valid,
  output logic              sink_sop,
  output logic              sink_eop,
  output logic [DATA_W-1:0] sink_real,
  output logic [DATA_W-1:0] sink_imag,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam int              IDX_W    = $clog2(FFT_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FFT_LEN - 1);

  state_t             state, state_nx;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic               out_vld;
  logic [DATA_W-1:0]  out_data;

  logic               f_push, f_pop, f_flush, f_full, f_empty;
  logic [DATA_W-1:0]  f_dout;

  logic               xfer, push_req, load, drop, out_clr;

  assign xfer     = sink_valid & sink_ready;
  assign push_req = sample_strobe & enable & (state != ST_PAD);
  // Output register refills whenever it is empty or its beat leaves this cycle.
  assign load     = (state == ST_STREAM) & ~f_empty & (~out_vld | xfer);
  // A full FIFO can only take a sample if the head is popped this cycle.
  assign drop     = push_req & f_full & ~load;
  assign idx_nx   = xfer ? idx + IDX_W'(1) : idx;

  assign f_push = push_req & ~drop;
  assign f_pop  = load;

  fft_sample_framer_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .MCLK  (MCLK),
    .reset (reset),
    .flush (f_flush),
    .push  (f_push),
    .pop   (f_pop),
    .din   (sample_in),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty)
  );

  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    f_flush  = 1'b0;
    out_clr  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) state_nx = ST_STREAM;
      end
      ST_STREAM: begin
        if (!enable) begin
          // Use the post-transfer index: an eop taken this cycle means the
          // frame is already complete and no padding is needed.
          f_flush  = 1'b1;
          out_clr  = 1'b1;
          state_nx = (idx_nx == '0) ? ST_IDLE : ST_PAD;
        end else if (drop) begin
          // A drop never coincides with a transfer, so idx is exact here.
          // At idx 0 nothing of the frame has left yet: just discard the
          // backlog and keep the presented beat.
          f_flush = 1'b1;
          if (idx != '0) begin
            out_clr  = 1'b1;
            state_nx = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        if (xfer && idx == IDX_LAST) state_nx = enable ? ST_STREAM : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      idx      <= '0;
      out_vld  <= 1'b0;
      out_data <= '0;
      overflow <= 1'b0;
    end else begin
      idx <= (state == ST_IDLE) ? '0 : idx_nx;

      if (out_clr) begin
        out_vld <= 1'b0;
      end else if (load) begin
        out_vld  <= 1'b1;
        out_data <= f_dout;
      end else if (xfer && state == ST_STREAM) begin
        out_vld <= 1'b0;
      end

      // Set has priority over clear.
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  assign sink_valid = (state == ST_PAD) | ((state == ST_STREAM) & out_vld);
  assign sink_real  = ((state == ST_STREAM) & out_vld) ? out_data : '0;
  assign sink_sop   = sink_valid & (idx == '0);
  assign sink_eop   = sink_valid & (idx == IDX_LAST);
  assign sink_imag  = '0;

endmodule

// File: tb/tb_fft_sample_framer.sv
// tb_fft_sample_framer
//   Directed bench: continuous ramp with a short stall, overflow into padding,
//   enable drop, mid-stall reset and overflow flag clearing.
module tb_fft_sample_framer;

  logic        MCLK = 1'b0;
  logic        reset;
  logic        enable;
  logic        sample_strobe;
  logic [23:0] sample_in;
  logic        sink_ready;
  logic        sink_valid, sink_sop, sink_eop;
  logic [23:0] sink_real, sink_imag;
  logic        overflow;
  logic        overflow_clr;

  fft_sample_framer #(.DATA_W(24), .FFT_LEN(4096), .FIFO_DEPTH(16)) dut (
    .MCLK          (MCLK),
    .reset         (reset),
    .enable        (enable),
    .sample_strobe (sample_strobe),
    .sample_in     (sample_in),
    .sink_ready    (sink_ready),
    .sink_valid    (sink_valid),
    .sink_sop      (sink_sop),
    .sink_eop      (sink_eop),
    .sink_real     (sink_real),
    .sink_imag     (sink_imag),
    .overflow      (overflow),
    .overflow_clr  (overflow_clr)
  );

  always #5 MCLK = ~MCLK;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [23:0] im;
    logic [23:0] re;
  } beat_t;

  int    n_chk = 0;
  int    n_bad = 0;
  int    stall_cnt = 0;
  bit    hold_chk = 1'b0;
  beat_t q[$];
  logic  prev_stall = 1'b0;
  beat_t prev_beat = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Record every accepted beat; optionally verify a stalled beat stays put.
  always @(negedge MCLK) begin
    if (hold_chk && prev_stall)
      chk("hold", 64'({sink_valid, sink_sop, sink_eop, sink_imag, sink_real}),
          64'({1'b1, prev_beat}));
    prev_stall <= sink_valid && !sink_ready;
    prev_beat  <= {sink_sop, sink_eop, sink_imag, sink_real};
    if (sink_valid && sink_ready)
      q.push_back({sink_sop, sink_eop, sink_imag, sink_real});
  end

  task automatic step();
    @(posedge MCLK);
    #1;
    if (stall_cnt > 0) begin
      stall_cnt--;
      if (stall_cnt == 0) sink_ready = 1'b1;
    end
  endtask

  task automatic send(input int v, input int per);
    sample_in     = 24'(v);
    sample_strobe = 1'b1;
    step();
    sample_strobe = 1'b0;
    overflow_clr  = 1'b0;
    repeat (per - 1) step();
  endtask

  task automatic exp_beat(input string tag, input int r, input logic s, input logic e);
    beat_t b;
    if (q.size() > 0) begin
      b = q.pop_front();
      chk(tag, 64'(b), 64'({s, e, 24'd0, 24'(r)}));
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; sample_strobe = 1'b0; sample_in = '0;
    sink_ready = 1'b1; overflow_clr = 1'b0;
    #1;
    chk("rst_valid", 64'(sink_valid), 64'd0);
    chk("rst_sop",   64'(sink_sop),   64'd0);
    chk("rst_eop",   64'(sink_eop),   64'd0);
    chk("rst_real",  64'(sink_real),  64'd0);
    chk("rst_imag",  64'(sink_imag),  64'd0);
    chk("rst_ovf",   64'(overflow),   64'd0);
    repeat (3) step();
    reset = 1'b1;
    step();
    enable = 1'b1;
    step();

    // Continuous ramp, two frames, with a 10-cycle stall on beat 1000.
    hold_chk = 1'b1;
    for (int v = 0; v < 8192; v++) begin
      if (v == 1000) begin sink_ready = 1'b0; stall_cnt = 10; end
      send(v, 8);
    end
    repeat (4) step();
    hold_chk = 1'b0;
    chk("t1_nbeats", 64'(q.size()), 64'd8192);
    for (int i = 0; i < 8192; i++)
      exp_beat("t1_beat", i, (i % 4096) == 0, (i % 4096) == 4095);
    chk("t1_ovf", 64'(overflow), 64'd0);
    q.delete();

    // Overflow: stall on beat 100, 17th strobe drops (clear pulse coincident).
    for (int v = 0; v < 100; v++) send(v, 8);
    sink_ready = 1'b0;
    send(100, 8);
    for (int k = 1; k <= 20; k++) begin
      overflow_clr = (k == 17);
      send(100 + k, 8);
      if (k == 16) chk("t3_ovf_pre", 64'(overflow), 64'd0);
      if (k == 17) begin
        chk("t3_ovf_set_wins", 64'(overflow),   64'd1);
        chk("t3_pad_valid",    64'(sink_valid), 64'd1);
        chk("t3_pad_zero",     64'(sink_real),  64'd0);
      end
    end
    sink_ready = 1'b1;
    repeat (4100) step();
    chk("t3_ovf_sticky", 64'(overflow), 64'd1);
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    chk("t6_ovf_clr", 64'(overflow), 64'd0);
    for (int i = 0; i < 4; i++) send(9000 + i, 8);
    repeat (2) step();
    chk("t3_nbeats", 64'(q.size()), 64'd4100);
    for (int i = 0; i < 100; i++)     exp_beat("t3_data", i, i == 0, 1'b0);
    for (int i = 100; i < 4096; i++)  exp_beat("t3_pad", 0, 1'b0, i == 4095);
    for (int i = 0; i < 4; i++)       exp_beat("t3_fresh", 9000 + i, i == 0, 1'b0);
    q.delete();

    // Enable drop with beat index at 2000.
    for (int i = 4; i < 2000; i++) send(9000 + i, 1);
    repeat (3) step();
    enable = 1'b0;
    step();
    chk("t4_pad_valid", 64'(sink_valid), 64'd1);
    chk("t4_pad_zero",  64'(sink_real),  64'd0);
    chk("t4_pad_sop",   64'(sink_sop),   64'd0);
    repeat (2200) step();
    chk("t4_idle_valid", 64'(sink_valid), 64'd0);
    enable = 1'b1;
    step();
    for (int i = 0; i < 3; i++) send(7000 + i, 8);
    chk("t4_nbeats", 64'(q.size()), 64'd4095);
    for (int i = 4; i < 2000; i++)    exp_beat("t4_data", 9000 + i, 1'b0, 1'b0);
    for (int i = 2000; i < 4096; i++) exp_beat("t4_pad", 0, 1'b0, i == 4095);
    for (int i = 0; i < 3; i++)       exp_beat("t4_reen", 7000 + i, i == 0, 1'b0);
    q.delete();

    // Reset while beat 1234 is stalled.
    for (int i = 3; i < 1234; i++) send(7000 + i, 1);
    repeat (3) step();
    chk("t5_nbeats", 64'(q.size()), 64'd1231);
    for (int i = 3; i < 1234; i++) exp_beat("t5_data", 7000 + i, 1'b0, 1'b0);
    q.delete();
    sink_ready = 1'b0;
    send(8234, 1);
    send(8235, 1);
    send(8236, 1);
    step();
    chk("t5_pre_valid", 64'(sink_valid), 64'd1);
    chk("t5_pre_real",  64'(sink_real),  64'd8234);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(sink_valid), 64'd0);
    chk("t5_rst_sop",   64'(sink_sop),   64'd0);
    chk("t5_rst_eop",   64'(sink_eop),   64'd0);
    chk("t5_rst_real",  64'(sink_real),  64'd0);
    sink_ready = 1'b1;
    step();
    reset = 1'b1;
    step();
    sample_in = 24'd42;
    sample_strobe = 1'b1;
    step();
    sample_strobe = 1'b0;
    chk("t5_lat0_valid", 64'(sink_valid), 64'd0);
    step();
    chk("t5_lat1_valid", 64'(sink_valid), 64'd1);
    chk("t5_lat1_sop",   64'(sink_sop),   64'd1);
    chk("t5_lat1_real",  64'(sink_real),  64'd42);
    repeat (2) step();
    chk("t5_post_nbeats", 64'(q.size()), 64'd1);
    exp_beat("t5_post", 42, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
